udp_tx_ctrl: RTL and testbench
==============================

# udp_tx_ctrl

Packet assembler that sits directly upstream of the UDP transmit path in the `gmii_tx_clk` domain. It collects a payload byte stream from the application into a single-packet word buffer, packing four bytes per 32-bit word with the first byte in the MSBs. On end-of-packet it pulses `tx_start_en` with the byte count. It then serves the transmitter's `tx_req` word requests until `tx_done`.

## Interface
- `MAX_WORDS`, 256: buffer depth in 32-bit words; the largest payload is `MAX_WORDS*4` bytes (1024).
- `TIMEOUT_CYC`, 65535: cycles allowed from `tx_start_en` to `tx_done` before the packet is abandoned.
- `clk` in 1: single clock; connected to `gmii_tx_clk`.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: payload byte valid.
- `wr_data` in 8: payload byte.
- `wr_last` in 1: qualifies `wr_en`; this byte ends the packet.
- `wr_ready` out 1: bytes are accepted only when high.
- `tx_start_en` out 1: one-cycle start pulse to the transmitter.
- `tx_byte_num` out 16: payload length in bytes; held stable from the start pulse until the end of SEND.
- `tx_req` in 1: transmitter requests the next word.
- `tx_data` out 32: requested word.
- `tx_done` in 1: transmitter finished the frame.
- `busy` out 1: high in every state except IDLE and FILL.
- `ovf_err` out 1: one-cycle pulse on each dropped byte.
- `tmo_err` out 1: one-cycle pulse when the timeout fires.

## Operation
- States:
  - IDLE: pointers cleared, `wr_ready=1`.
  - FILL: at least one byte accepted.
  - START: one cycle; `tx_start_en=1`.
  - SEND: serving `tx_req`, waiting for `tx_done`.
- Transitions:
  - IDLE→FILL: accepted `wr_en` without `wr_last`.
  - IDLE→START: accepted `wr_en` with `wr_last` (1-byte packet).
  - FILL→START: accepted `wr_en` with `wr_last`.
  - START→SEND: unconditional.
  - SEND→IDLE: on `tx_done`, or when the timeout counter reaches `TIMEOUT_CYC`.
- `wr_ready` = 1 in IDLE and FILL, 0 in START and SEND.
- Byte packing:
  - Byte index k goes to word k/4, lane 3-(k%4). Lane 3 = bits [31:24].
  - A word is written to the RAM when lane 0 fills or when `wr_last` arrives.
  - Unused lanes of a partial final word are written as 0x00.
- Byte count:
  - 16-bit, incremented per accepted byte; `tx_byte_num` = count including the `wr_last` byte.
  - Bytes arriving when count = `MAX_WORDS*4` are dropped and pulse `ovf_err`.
  - If that dropped byte carries `wr_last`, the packet still ends and is sent truncated at `MAX_WORDS*4`.
- Read side:
  - Each cycle with `tx_req=1` in SEND reads the word at the read pointer; the pointer then increments.
  - Requests past the last stored word return 0x00000000.
  - `tx_req` outside SEND is ignored; `tx_data` holds its value.
- `tx_done` outside SEND is ignored.
- On SEND→IDLE, the write/read pointers, byte count and timeout counter clear. RAM contents are not cleared.

## Timing
- Reset values: `wr_ready=1`, `tx_start_en=0`, `tx_byte_num=0`, `tx_data=0`, `busy=0`, `ovf_err=0`, `tmo_err=0`; state IDLE.
- Start latency: `tx_start_en` is high exactly in the cycle after the `wr_last` byte is accepted.
- Read latency is one cycle: `tx_data` is valid the cycle after the `tx_req` that requested it, and holds until the next request. Back-to-back requests give one word per cycle.
- Timeout counter:
  - Starts at 0 in the START cycle; counts in SEND.
  - At count `TIMEOUT_CYC`: `tmo_err` pulses and the state goes to IDLE the next cycle.
  - If `tx_done` arrives in that same cycle, `tx_done` wins and `tmo_err` stays 0.
- `wr_en` together with the SEND→IDLE transition cycle is not accepted (`wr_ready=0` that cycle). `wr_ready` rises the following cycle.
- Asynchronous reset mid-packet or mid-SEND: all outputs return to reset values immediately; the partial packet is discarded.

## Structure
- Shared package/header `udp_tx_pkg`: state encodings (IDLE/FILL/START/SEND), default `MAX_WORDS` and `TIMEOUT_CYC`.
- Sub-module `udp_tx_buf_ram`:
  - Simple dual-port RAM, `MAX_WORDS` x 32.
  - Synchronous write port and synchronous one-cycle read port, same clock.
  - Its read register provides `tx_data`.
- Top contains the FSM, byte packer, byte counter, read pointer and timeout counter.

## Test plan
- Bytes 11,22,33,44,55 with `wr_last` on 55:
  - One cycle later, `tx_start_en`=1 for one cycle with `tx_byte_num`=5.
  - Two `tx_req` pulses return 0x11223344 then 0x55000000, each one cycle after its request.
  - `tx_done` returns to IDLE with `wr_ready`=1 next cycle.
- Single byte AB with `wr_last`: IDLE→START directly; `tx_byte_num`=1; word 0xAB000000.
- 1030 bytes with `wr_last` on the last: six `ovf_err` pulses; `tx_byte_num`=1024; 256 words read; a 257th `tx_req` returns 0.
- `wr_en` held high during SEND: no bytes accepted, `wr_ready`=0, count unchanged, and the next packet starts at word 0.
- `TIMEOUT_CYC`=100, no `tx_done`: `tmo_err` pulses 100 cycles after START and the state is IDLE.
- `rst_n` low mid-SEND: outputs reach reset values immediately; a fresh 4-byte packet afterwards reads back correctly.

Source files
------------

// File: rtl/udp_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : udp_tx_pkg
//  Description : Shared definitions for the UDP transmit packet assembler:
//                controller state encoding and default sizing parameters.
//  Contents    : state_t (IDLE/FILL/START/SEND), DEF_MAX_WORDS,
//                DEF_TIMEOUT_CYC
//  Revision    : 1.0 - initial release
// ============================================================================
package udp_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_START = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    localparam int DEF_MAX_WORDS   = 256;
    localparam int DEF_TIMEOUT_CYC = 65535;

endpackage
`default_nettype wire

// File: rtl/udp_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : udp_tx_ctrl_if
//  Description : Bundles the payload-write and transmitter-side signals of
//                udp_tx_ctrl.
//  Modports    : master - application/transmitter side (drives wr_*, tx_req,
//                         tx_done; observes status and read data)
//                slave  - udp_tx_ctrl side
//  Revision    : 1.0 - initial release
// ============================================================================
interface udp_tx_ctrl_if;

    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_last;
    logic        wr_ready;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req;
    logic [31:0] tx_data;
    logic        tx_done;
    logic        busy;
    logic        ovf_err;
    logic        tmo_err;

    modport master (
        output wr_en, wr_data, wr_last, tx_req, tx_done,
        input  wr_ready, tx_start_en, tx_byte_num, tx_data, busy, ovf_err, tmo_err
    );

    modport slave (
        input  wr_en, wr_data, wr_last, tx_req, tx_done,
        output wr_ready, tx_start_en, tx_byte_num, tx_data, busy, ovf_err, tmo_err
    );

endinterface
`default_nettype wire

// File: rtl/udp_tx_buf_ram.sv
`default_nettype none
// ============================================================================
//  Module      : udp_tx_buf_ram
//  Description : Simple dual-port single-packet word buffer, DEPTH x 32.
//                Synchronous write; synchronous one-cycle read whose output
//                register holds between reads.
//  Ports       : clk, rst_n     - clock, async active-low reset (read reg)
//                we/waddr/wdata - write port
//                re/raddr       - read request / address
//                rclr           - load the read register with zero instead
//                rdata          - read register
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_buf_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic          rclr,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Storage is deliberately not reset; only valid words are ever read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/udp_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : udp_tx_ctrl
//  Description : Packet assembler ahead of the UDP transmit path. Packs the
//                payload byte stream four bytes per word (first byte in the
//                MSBs) into a single-packet buffer, pulses tx_start_en with
//                the byte count on end-of-packet, then serves tx_req word
//                reads until tx_done or a timeout.
//  Ports       : clk    - gmii_tx_clk
//                rst_n  - asynchronous active-low reset
//                bus    - udp_tx_ctrl_if.slave (write side, transmitter
//                         side, status pulses)
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_ctrl
    import udp_tx_pkg::*;
#(
    parameter int MAX_WORDS   = DEF_MAX_WORDS,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic         clk,
    input  logic         rst_n,
    udp_tx_ctrl_if.slave bus
);

    localparam int          AW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [15:0] MAX_BYTES = 16'(MAX_WORDS * 4);

    state_t         state;
    state_t         state_nxt;

    logic [15:0]    byte_cnt;
    logic [31:0]    pack_q;       // lanes of the word currently being packed
    logic [15:0]    byte_num_q;
    logic [15:0]    rd_ptr;
    logic [TW-1:0]  tmo_cnt;

    logic           ready;
    logic           accept;
    logic           full;
    logic           take;
    logic           drop;
    logic [1:0]     lane;
    logic [31:0]    word;
    logic           ram_we;
    logic           rd_req;
    logic           in_range;
    logic           tmo_at;
    logic           send_end;

    assign ready  = (state == ST_IDLE) || (state == ST_FILL);
    assign accept = bus.wr_en && ready;
    assign full   = (byte_cnt == MAX_BYTES);
    assign take   = accept && !full;
    assign drop   = accept && full;
    assign lane   = 2'd3 - byte_cnt[1:0];

    // Word image after merging the incoming byte: lanes above it keep the
    // bytes already packed, lanes below it are zero so a partial final word
    // is stored zero-padded without a separate clear.
    always_comb begin
        word = '0;
        for (int l = 0; l < 4; l++) begin
            if (l > int'(lane)) begin
                word[l*8 +: 8] = pack_q[l*8 +: 8];
            end else if (l == int'(lane)) begin
                word[l*8 +: 8] = bus.wr_data;
            end
        end
    end

    assign ram_we   = take && ((lane == 2'd0) || bus.wr_last);
    assign rd_req   = (state == ST_SEND) && bus.tx_req;
    // Word k holds data only if byte 4k exists.
    assign in_range = ({rd_ptr, 2'b00} < {2'b00, byte_num_q});
    assign tmo_at   = (tmo_cnt == TW'(TIMEOUT_CYC));
    assign send_end = (state == ST_SEND) && (bus.tx_done || tmo_at);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.wr_ready    = ready;
        bus.tx_start_en = 1'b0;
        bus.busy        = 1'b0;
        bus.ovf_err     = drop;
        // tx_done in the same cycle as the timeout takes precedence.
        bus.tmo_err     = (state == ST_SEND) && tmo_at && !bus.tx_done;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = bus.wr_last ? ST_START : ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept && bus.wr_last) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                bus.tx_start_en = 1'b1;
                bus.busy        = 1'b1;
                state_nxt       = ST_SEND;
            end
            ST_SEND: begin
                bus.busy = 1'b1;
                if (bus.tx_done || tmo_at) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: byte counter, packer, length, read pointer, timeout
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            pack_q     <= '0;
            byte_num_q <= '0;
            rd_ptr     <= '0;
            tmo_cnt    <= '0;
        end else if (send_end) begin
            byte_cnt <= '0;
            rd_ptr   <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (take) begin
                byte_cnt <= byte_cnt + 16'd1;
                pack_q   <= word;
            end
            // A dropped last byte still ends the packet, truncated at full.
            if (accept && bus.wr_last) begin
                byte_num_q <= take ? (byte_cnt + 16'd1) : byte_cnt;
            end
            if (rd_req && in_range) begin
                rd_ptr <= rd_ptr + 16'd1;
            end
            // Zero during START, so the value in SEND equals cycles since START.
            if ((state == ST_START) || (state == ST_SEND)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    assign bus.tx_byte_num = byte_num_q;

    udp_tx_buf_ram #(
        .DEPTH (MAX_WORDS),
        .AW    (AW)
    ) u_buf_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (byte_cnt[AW+1:2]),
        .wdata (word),
        .re    (rd_req && in_range),
        .rclr  (rd_req && !in_range),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (bus.tx_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_udp_tx_ctrl
//  Description : Self-checking bench for udp_tx_ctrl. Random payloads are
//                compared against a byte-list reference model (word w is
//                bytes 4w..4w+3 of the truncated payload, zero beyond it).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_tx_ctrl;

    localparam int MAXB      = 1024;
    localparam int TMO_MAIN  = 1000;
    localparam int TMO_SHORT = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    udp_tx_ctrl_if bus();
    udp_tx_ctrl_if bus2();

    udp_tx_ctrl #(.MAX_WORDS(256), .TIMEOUT_CYC(TMO_MAIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    udp_tx_ctrl #(.MAX_WORDS(256), .TIMEOUT_CYC(TMO_SHORT)) dut_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          ovf_total = 0;
    logic [7:0]  pkt[$];
    logic [31:0] exp_data;

    always @(negedge clk) if (bus.ovf_err === 1'b1) ovf_total <= ovf_total + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int payload_len();
        return (pkt.size() > MAXB) ? MAXB : pkt.size();
    endfunction

    // Reference: word w = bytes 4w..4w+3, first byte in the MSBs, zero past end.
    function automatic logic [31:0] exp_word(input int w);
        logic [31:0] v;
        int nb;
        v  = '0;
        nb = payload_len();
        for (int j = 0; j < 4; j++) begin
            v = {v[23:0], ((4*w + j) < nb) ? pkt[4*w + j] : 8'h00};
        end
        return v;
    endfunction

    task automatic fill_rand(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
    endtask

    task automatic load_bytes(input int gap_pct);
        int i;
        int n;
        i = 0;
        n = pkt.size();
        while (i < n) begin
            if (i > 0 && $urandom_range(0, 99) < gap_pct) begin
                bus.wr_en   = 1'b0;
                bus.wr_last = 1'b0;
            end else begin
                bus.wr_en   = 1'b1;
                bus.wr_data = pkt[i];
                bus.wr_last = (i == n - 1);
                i++;
            end
            @(negedge clk);
            chk("wr_ready_fill", bus.wr_ready, 1);
            chk("busy_fill", bus.busy, 0);
            @(posedge clk); #1;
        end
        bus.wr_en   = 1'b0;
        bus.wr_last = 1'b0;
    endtask

    task automatic check_start(input int ovf_base, input bit hold);
        bus.wr_en = hold;
        @(negedge clk);
        chk("start_en", bus.tx_start_en, 1);
        chk("byte_num", bus.tx_byte_num, payload_len());
        chk("wr_ready_start", bus.wr_ready, 0);
        chk("busy_start", bus.busy, 1);
        chk("ovf_count", ovf_total - ovf_base, pkt.size() - payload_len());
        @(posedge clk); #1;
    endtask

    task automatic serve(input int nreq, input bit hold);
        int r;
        r = 0;
        while (r < nreq) begin
            bus.tx_req = ($urandom_range(0, 3) != 0);
            if (hold) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 8'($urandom);
                bus.wr_last = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            chk("tx_data", bus.tx_data, exp_data);
            chk("wr_ready_send", bus.wr_ready, 0);
            chk("start_en_send", bus.tx_start_en, 0);
            chk("byte_num_hold", bus.tx_byte_num, payload_len());
            if (bus.tx_req) begin
                exp_data = exp_word(r);
                r++;
            end
            @(posedge clk); #1;
        end
        bus.tx_req = 1'b0;
        @(negedge clk);
        chk("tx_data_last", bus.tx_data, exp_data);
        @(posedge clk); #1;
    endtask

    task automatic finish_done(input bit hold);
        bus.tx_req  = 1'b0;
        bus.tx_done = 1'b1;
        bus.wr_en   = hold;
        @(negedge clk);
        chk("wr_ready_done", bus.wr_ready, 0);
        chk("tmo_err_done", bus.tmo_err, 0);
        @(posedge clk); #1;
        bus.tx_done = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_last = 1'b0;
        @(negedge clk);
        chk("busy_idle", bus.busy, 0);
        chk("wr_ready_idle", bus.wr_ready, 1);
        chk("tx_data_idle", bus.tx_data, exp_data);
        @(posedge clk); #1;
    endtask

    task automatic full_packet(input int gap_pct, input int extra, input bit hold);
        int base;
        base = ovf_total;
        load_bytes(gap_pct);
        check_start(base, hold);
        serve((payload_len() + 3) / 4 + extra, hold);
        finish_done(hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int base;
        bit seen;
        bus.wr_en = 0; bus.wr_data = 0; bus.wr_last = 0; bus.tx_req = 0; bus.tx_done = 0;
        bus2.wr_en = 0; bus2.wr_data = 0; bus2.wr_last = 0; bus2.tx_req = 0; bus2.tx_done = 0;
        exp_data = '0;

        #3;
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_start_en", bus.tx_start_en, 0);
        chk("rst_byte_num", bus.tx_byte_num, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovf", bus.ovf_err, 0);
        chk("rst_tmo", bus.tmo_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed five-byte packet
        pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        full_packet(0, 0, 0);
        chk("word1_5b", exp_data, 32'h55000000);

        // Single byte packet
        pkt = '{8'hAB};
        full_packet(0, 0, 0);

        // tx_req / tx_done in IDLE are ignored
        bus.tx_req = 1'b1; bus.tx_done = 1'b1;
        @(negedge clk);
        chk("idle_ign_busy", bus.busy, 0);
        @(posedge clk); #1;
        bus.tx_req = 1'b0; bus.tx_done = 1'b0;
        @(negedge clk);
        chk("idle_ign_data", bus.tx_data, exp_data);
        chk("idle_ign_ready", bus.wr_ready, 1);
        @(posedge clk); #1;

        // Overflow: 1030 bytes, 257 reads
        fill_rand(1030);
        full_packet(0, 1, 0);

        // wr_en held during START/SEND, then a fresh packet from word 0
        fill_rand(7);
        full_packet(0, 0, 1);
        fill_rand(6);
        full_packet(0, 0, 0);

        // Random packets
        for (int p = 0; p < 10; p++) begin
            fill_rand($urandom_range(1, 40));
            full_packet(25, $urandom_range(0, 2), 0);
        end

        // Asynchronous reset mid-SEND
        fill_rand(9);
        base = ovf_total;
        load_bytes(0);
        check_start(base, 0);
        serve(1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_ready", bus.wr_ready, 1);
        chk("arst_start_en", bus.tx_start_en, 0);
        chk("arst_byte_num", bus.tx_byte_num, 0);
        chk("arst_tx_data", bus.tx_data, 0);
        chk("arst_busy", bus.busy, 0);
        exp_data = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_rand(4);
        full_packet(0, 0, 0);

        // Timeout on the short-timeout instance
        for (int i = 0; i < 3; i++) begin
            bus2.wr_en = 1'b1; bus2.wr_data = 8'($urandom); bus2.wr_last = (i == 2);
            @(posedge clk); #1;
        end
        bus2.wr_en = 1'b0; bus2.wr_last = 1'b0;
        @(negedge clk);
        chk("t_start_en", bus2.tx_start_en, 1);
        t0 = cyc;
        seen = 0;
        for (int k = 0; k < 2 * TMO_SHORT && !seen; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus2.tmo_err) begin
                seen = 1;
                chk("t_tmo_delay", cyc - t0, TMO_SHORT);
                chk("t_tmo_busy", bus2.busy, 1);
            end
        end
        chk("t_tmo_seen", seen, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t_idle_busy", bus2.busy, 0);
        chk("t_idle_tmo", bus2.tmo_err, 0);
        chk("t_idle_ready", bus2.wr_ready, 1);
        @(posedge clk); #1;

        // tx_done in the timeout cycle wins
        bus2.wr_en = 1'b1; bus2.wr_data = 8'h5A; bus2.wr_last = 1'b1;
        @(posedge clk); #1;
        bus2.wr_en = 1'b0; bus2.wr_last = 1'b0;
        @(negedge clk);
        chk("t2_start_en", bus2.tx_start_en, 1);
        for (int k = 0; k < TMO_SHORT; k++) begin
            @(posedge clk); #1;
        end
        bus2.tx_done = 1'b1;
        @(negedge clk);
        chk("t2_tmo_tie", bus2.tmo_err, 0);
        chk("t2_busy_tie", bus2.busy, 1);
        @(posedge clk); #1;
        bus2.tx_done = 1'b0;
        @(negedge clk);
        chk("t2_idle_busy", bus2.busy, 0);
        chk("t2_idle_tmo", bus2.tmo_err, 0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
